// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Brief    : Multi-cycle MIPS multiply/divide sequencer holding HI/LO.
//            Results are computed when the operation is accepted and are
//            committed after a fixed MULT_CYCLES / DIV_CYCLES busy window.
//            Raises a stall request while an MD-class instruction in IF/ID
//            would observe an in-flight operation.
//            Optional macro MDU_CANCEL_EN adds a 'cancel' input that aborts
//            an in-flight operation without touching HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_in_id,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic        w_cancel;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arithmetic datapath, evaluated on the operands presented with start
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_div_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed division works on magnitudes so that truncation toward zero
    // and the 0x80000000 / -1 overflow case fall out without special-casing.
    assign w_rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign w_q_mag  = w_rs_mag / w_rt_mag;
    assign w_r_mag  = w_rs_mag % w_rt_mag;
    assign w_q_s    = (rs_val[31] ^ rt_val[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s    = rs_val[31] ? (~w_r_mag + 32'd1) : w_r_mag;

    assign w_q_u    = rs_val / rt_val;
    assign w_r_u    = rs_val % rt_val;

    assign w_div_zero = (rt_val == 32'd0);

    // Select the HI/LO pair for the requested operation
    always_comb begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        case (md_op)
            2'b00: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'b01: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'b10: begin
                w_res_hi = w_div_zero ? rs_val : w_r_s;
                w_res_lo = w_div_zero ? 32'hFFFF_FFFF : w_q_s;
            end
            default: begin
                w_res_hi = w_div_zero ? rs_val : w_r_u;
                w_res_lo = w_div_zero ? 32'hFFFF_FFFF : w_q_u;
            end
        endcase
    end

    // Next-state logic: accept ops / mthi / mtlo in IDLE, count down in BUSY
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A cancelled start is simply dropped; strobes alongside
                    // start are always dropped.
                    if (!w_cancel) begin
                        pend_hi_d = w_res_hi;
                        pend_lo_d = w_res_lo;
                        cnt_d     = md_op[1] ? c_DIV_CNT : c_MULT_CNT;
                        state_d   = S_BUSY;
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            S_BUSY: begin
                if (w_cancel) begin
                    pend_hi_d = 32'd0;
                    pend_lo_d = 32'd0;
                    cnt_d     = 4'd0;
                    state_d   = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and HI/LO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == S_BUSY);
    assign stall = md_in_id & (start | busy);

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Brief    : Self-checking bench for mdu_sequencer. A cycle-indexed model
//            tracks HI/LO and the busy window; directed cases pin the model
//            with literal values, then randomized traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        md_in_id = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .md_in_id (md_in_id),
`ifdef MDU_CANCEL_EN
        .cancel   (cancel),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic from the instruction definitions, in 64-bit ints
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int                ia, ib;
        longint            sa, sb, q, r, p;
        longint unsigned   ua, ub, uq, ur, up;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (op)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin up = ua * ub; return up; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub; ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Model: cyc numbers clock cycles; an op accepted in cycle t is busy
    // through cycle m_end = t+N and commits at the edge closing m_end.
    int          cyc = 0;
    int          m_end = -1;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    logic        m_busy;
    logic        m_cancel;

`ifdef MDU_CANCEL_EN
    assign m_cancel = cancel;
`else
    assign m_cancel = 1'b0;
`endif

    assign m_busy = (cyc <= m_end);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_end <= -1;
        end else if (cyc > m_end) begin
            if (start) begin
                if (!m_cancel) begin
                    m_pend <= ref_md(md_op, rs_val, rt_val);
                    m_end  <= cyc + (md_op[1] ? DIV_N : MULT_N);
                end
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
            end
        end else begin
            if (m_cancel) begin
                m_end <= cyc;
            end else if (cyc == m_end) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_stall", {31'd0, stall}, {31'd0, md_in_id & (start | m_busy)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure its busy window, then check literal results
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_exp, input logic [31:0] hi_exp, input logic [31:0] lo_exp,
                         input string tag);
        int n;
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        @(negedge clk);
        chk({tag, "_stall_t"}, {31'd0, stall}, {31'd0, md_in_id});
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n = 0;
        while (n <= 40) begin
            @(negedge clk);
            if (!busy) break;
            chk({tag, "_stall_busy"}, {31'd0, stall}, {31'd0, md_in_id});
            n++;
            tick();
        end
        chk({tag, "_latency"}, n, n_exp);
        chk({tag, "_hi"}, hi, hi_exp);
        chk({tag, "_lo"}, lo, lo_exp);
        chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();

        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf");
        do_op(2'b11, 32'h0000_0055, 32'd0, 10, 32'h0000_0055, 32'hFFFF_FFFF, "divu_zero");

        md_in_id = 1'b1;
        do_op(2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu_stall");
        md_in_id = 1'b0;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, "multu_nostall");

        hi_we = 1'b1; wdata = 32'h1234;
        tick();
        hi_we = 1'b0;
        @(negedge clk);
        chk("mthi", hi, 32'h1234);
        tick();

        lo_we = 1'b1; wdata = 32'hAAAA;
        do_op(2'b01, 32'd2, 32'd3, 5, 32'd0, 32'd6, "multu_vs_mtlo");

        // Reset two cycles into a mult: no commit may follow
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        md_op = 2'b00; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        tick();
        repeat (8) tick();
        @(negedge clk);
        chk("rstmid_nocommit_lo", lo, 32'd0);
        tick();

`ifdef MDU_CANCEL_EN
        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        tick();
        lo_we = 1'b0;
        md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'h11);
        chk("cancel_lo", lo, 32'h22);
        tick();
        repeat (12) tick();
        @(negedge clk);
        chk("cancel_hold_lo", lo, 32'h22);
        tick();
`endif

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 3) == 0);
            md_op    = 2'($urandom_range(0, 3));
            rs_val   = pick_operand();
            rt_val   = pick_operand();
            hi_we    = ($urandom_range(0, 7) == 0);
            lo_we    = ($urandom_range(0, 7) == 0);
            wdata    = $urandom;
            md_in_id = $urandom_range(0, 1) == 1;
`ifdef MDU_CANCEL_EN
            cancel   = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end
        reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
